mole_array_scorer: RTL
======================

MOLE_ARRAY_SCORER -- requirements
Module: mole_array_scorer

Interface
REQ-001 Parameter N_MOLES, default 8: number of independent moles, 1..16.
REQ-002 Parameter HW, default 5: height register width per mole.
REQ-003 Parameter MAX_HEIGHT, default 20: fully-raised height, 1..2^HW-1.
REQ-004 Parameter WAIT_TICKS, default 5: wait_tick pulses a mole stays fully up, 1..255.
REQ-005 Parameter DIGITS, default 4: BCD digits per total counter.
REQ-006 clock  in  1  sole clock, all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 rl_tick  in  1  single-cycle enable; one height step per pulse.
REQ-009 wait_tick  in  1  single-cycle enable; one wait step per pulse.
REQ-010 go  in  N_MOLES  per-mole rise request, level-sampled.
REQ-011 mole_hit  in  N_MOLES  per-mole hammer input, level; rising edge is the event.
REQ-012 mheight  out  N_MOLES*HW  mole i height at [i*HW +: HW].
REQ-013 hiding  out  N_MOLES  1 = mole i in HIDE.
REQ-014 total_score  out  4*DIGITS  BCD hit total; ones digit at [3:0].
REQ-015 total_rise  out  4*DIGITS  BCD rise total; same digit order.
REQ-016 total_miss  out  4*DIGITS  BCD miss total; same digit order.

Function
REQ-017 Each mole SHALL run an independent FSM: HIDE, RISE, UP, FALL.
- HIDE: height 0, hiding=1; go[i]=1 -> RISE next cycle, total_rise += 1.
- RISE: on rl_tick height+1; when new height == MAX_HEIGHT -> UP, wait count cleared.
- UP: on wait_tick wait count+1; when new count == WAIT_TICKS -> FALL.
- FALL: on rl_tick height-1; when new height == 0 -> HIDE; FALL with height already 0 -> HIDE next cycle without tick.
REQ-018 go[i] outside HIDE SHALL be ignored.
REQ-019 Hit event = mole_hit[i] 1 this cycle and 0 previous cycle (registered copy, cleared by reset).
REQ-020 Hit in RISE or UP with per-appearance hit flag clear SHALL: total_score += 1, set flag, force FALL next cycle, height held.
REQ-021 Hit in HIDE, in FALL, or with flag already set SHALL not score.
REQ-022 Hit flag SHALL clear on HIDE->RISE.
REQ-023 Same-cycle events on several moles SHALL each count: total += population count of qualifying events that cycle.
REQ-024 Totals SHALL update one cycle after the qualifying cycle (registered, one-cycle latency).
REQ-025 Totals SHALL be valid BCD (each digit 0..9) and saturate at all-9s; no wrap.
REQ-026 Hit and rl_tick in same cycle: hit wins, no height change that cycle.
REQ-027 mheight and hiding SHALL be direct register outputs, no combinational path from inputs.

Reset
REQ-028 reset=1 at clock edge SHALL force every mole to HIDE, height 0, wait count 0, hit flag 0, hit-edge registers 0.
REQ-029 reset SHALL clear all three totals to 0; hiding reset value all-ones; mheight 0.
REQ-030 reset mid-rise or mid-count SHALL discard in-flight events; no count increment in the reset cycle.

Configuration
REQ-031 Macro MOLE_ARRAY_SCORER_MISS_COUNT_EN defined: FALL->HIDE with hit flag clear increments total_miss by 1 (same population/saturation rules).
REQ-032 Macro undefined: miss logic absent, total_miss tied to 0.

Verification
REQ-033 N_MOLES=2, MAX_HEIGHT=3, WAIT_TICKS=2, rl_tick/wait_tick always 1; go[0] one cycle -> height 0,1,2,3 then UP 2 cycles, down 2,1,0, hiding[0]=1; total_rise=0x0001, total_score=0.
REQ-034 Same setup, mole_hit[0] rising while height=2 in RISE -> total_score=0x0001 next cycle, FALL, height 2,1,0; holding mole_hit high gives no second score.
REQ-035 go=2'b11 same cycle, both hit same cycle -> total_rise=0x0002, total_score=0x0002.
REQ-036 DIGITS=2, 100 scored hits -> total_score=0x99 after 99th and stays 0x99.
REQ-037 Reset asserted with mole 0 at height 2 in RISE -> next cycle mheight=0, hiding=all-ones, totals 0.
REQ-038 Macro defined, unhit full cycle -> total_miss=0x0001; macro undefined -> total_miss stays 0.

Source files
------------

// File: rtl/mole_array_scorer_if.sv
// Mole array scorer bus: tick enables, per-mole go/hit requests,
// per-mole height/hiding status and the three BCD totals.
interface mole_array_scorer_if #(
  parameter int N_MOLES = 8,
  parameter int HW      = 5,
  parameter int DIGITS  = 4
);
  logic                    rl_tick;
  logic                    wait_tick;
  logic [N_MOLES-1:0]      go;
  logic [N_MOLES-1:0]      mole_hit;
  logic [N_MOLES*HW-1:0]   mheight;
  logic [N_MOLES-1:0]      hiding;
  logic [4*DIGITS-1:0]     total_score;
  logic [4*DIGITS-1:0]     total_rise;
  logic [4*DIGITS-1:0]     total_miss;

  modport master (
    output rl_tick, wait_tick, go, mole_hit,
    input  mheight, hiding,
    input  total_score, total_rise, total_miss
  );

  modport slave (
    input  rl_tick, wait_tick, go, mole_hit,
    output mheight, hiding,
    output total_score, total_rise, total_miss
  );
endinterface

// File: rtl/mole_array_scorer.sv
// Array of independent whack-a-mole FSMs with BCD hit/rise/miss totals.
// Ports: clock, reset (sync, active-high), bus (mole_array_scorer_if.slave).
// Optional: MOLE_ARRAY_SCORER_MISS_COUNT_EN enables the total_miss counter.
module mole_array_scorer #(
  parameter int N_MOLES    = 8,
  parameter int HW         = 5,
  parameter int MAX_HEIGHT = 20,
  parameter int WAIT_TICKS = 5,
  parameter int DIGITS     = 4
) (
  input  logic clock,
  input  logic reset,
  mole_array_scorer_if.slave bus
);

  typedef enum logic [1:0] {
    S_HIDE,
    S_RISE,
    S_UP,
    S_FALL
  } state_t;

  localparam logic [HW-1:0] MAXH = HW'(MAX_HEIGHT);
  localparam logic [7:0]    MAXW = 8'(WAIT_TICKS);
  localparam int            TW   = 4 * DIGITS;

  state_t             r_state     [N_MOLES];
  state_t             w_state_nx  [N_MOLES];
  logic [HW-1:0]      r_height    [N_MOLES];
  logic [HW-1:0]      w_height_nx [N_MOLES];
  logic [7:0]         r_wait      [N_MOLES];
  logic [7:0]         w_wait_nx   [N_MOLES];
  logic [N_MOLES-1:0] r_flag;
  logic [N_MOLES-1:0] w_flag_nx;
  logic [N_MOLES-1:0] r_hit_q;
  logic [N_MOLES-1:0] r_hiding;
  logic [N_MOLES-1:0] w_hit_ev;
  logic [N_MOLES-1:0] w_rise_ev;
  logic [N_MOLES-1:0] w_score_ev;
  logic [TW-1:0]      r_score;
  logic [TW-1:0]      r_rise;

  function automatic logic [4:0] popcnt(
    input logic [N_MOLES-1:0] v
  );
    logic [4:0] s;
    s = '0;
    for (int k = 0; k < N_MOLES; k++)
      s = s + 5'(v[k]);
    return s;
  endfunction

  // Ripple a small binary increment through BCD digits;
  // a carry out of the top digit pins the total at all-9s.
  function automatic logic [TW-1:0] bcd_add(
    input logic [TW-1:0] a,
    input logic [4:0]    n
  );
    logic [TW-1:0] r;
    logic [5:0]    s;
    logic [4:0]    c;
    r = a;
    c = n;
    for (int d = 0; d < DIGITS; d++) begin
      s = {2'b00, a[4*d +: 4]} + {1'b0, c};
      if (s >= 6'd20) begin
        r[4*d +: 4] = 4'(s - 6'd20);
        c = 5'd2;
      end else if (s >= 6'd10) begin
        r[4*d +: 4] = 4'(s - 6'd10);
        c = 5'd1;
      end else begin
        r[4*d +: 4] = s[3:0];
        c = 5'd0;
      end
    end
    if (c != 5'd0)
      r = {DIGITS{4'h9}};
    return r;
  endfunction

  assign w_hit_ev = bus.mole_hit & ~r_hit_q;

  always_comb begin
    for (int i = 0; i < N_MOLES; i++) begin
      w_state_nx[i]  = r_state[i];
      w_height_nx[i] = r_height[i];
      w_wait_nx[i]   = r_wait[i];
      w_flag_nx[i]   = r_flag[i];
      w_rise_ev[i]   = 1'b0;
      w_score_ev[i]  = 1'b0;
      unique case (r_state[i])
        S_HIDE: begin
          if (bus.go[i]) begin
            w_state_nx[i]  = S_RISE;
            w_height_nx[i] = '0;
            w_wait_nx[i]   = '0;
            w_flag_nx[i]   = 1'b0;
            w_rise_ev[i]   = 1'b1;
          end
        end
        S_RISE: begin
          // A hit freezes the height even when rl_tick is also high.
          if (w_hit_ev[i] && !r_flag[i]) begin
            w_score_ev[i] = 1'b1;
            w_flag_nx[i]  = 1'b1;
            w_state_nx[i] = S_FALL;
          end else if (bus.rl_tick) begin
            w_height_nx[i] = r_height[i] + 1'b1;
            if (r_height[i] + 1'b1 == MAXH) begin
              w_state_nx[i] = S_UP;
              w_wait_nx[i]  = '0;
            end
          end
        end
        S_UP: begin
          if (w_hit_ev[i] && !r_flag[i]) begin
            w_score_ev[i] = 1'b1;
            w_flag_nx[i]  = 1'b1;
            w_state_nx[i] = S_FALL;
          end else if (bus.wait_tick) begin
            w_wait_nx[i] = r_wait[i] + 1'b1;
            if (r_wait[i] + 1'b1 == MAXW)
              w_state_nx[i] = S_FALL;
          end
        end
        S_FALL: begin
          if (r_height[i] == '0) begin
            w_state_nx[i] = S_HIDE;
          end else if (bus.rl_tick) begin
            w_height_nx[i] = r_height[i] - 1'b1;
            if (r_height[i] == HW'(1))
              w_state_nx[i] = S_HIDE;
          end
        end
        default: begin
          w_state_nx[i] = S_HIDE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_MOLES; i++) begin
        r_state[i]  <= S_HIDE;
        r_height[i] <= '0;
        r_wait[i]   <= '0;
      end
      r_flag   <= '0;
      r_hit_q  <= '0;
      r_hiding <= '1;
      r_score  <= '0;
      r_rise   <= '0;
    end else begin
      for (int i = 0; i < N_MOLES; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_height[i] <= w_height_nx[i];
        r_wait[i]   <= w_wait_nx[i];
        r_hiding[i] <= (w_state_nx[i] == S_HIDE);
      end
      r_flag  <= w_flag_nx;
      r_hit_q <= bus.mole_hit;
      r_score <= bcd_add(r_score, popcnt(w_score_ev));
      r_rise  <= bcd_add(r_rise, popcnt(w_rise_ev));
    end
  end

`ifdef MOLE_ARRAY_SCORER_MISS_COUNT_EN
  logic [N_MOLES-1:0] w_miss_ev;
  logic [TW-1:0]      r_miss;

  // A miss is an appearance that drops back into hiding unhit.
  always_comb begin
    for (int i = 0; i < N_MOLES; i++)
      w_miss_ev[i] = (r_state[i] == S_FALL) &&
                     (w_state_nx[i] == S_HIDE) &&
                     !r_flag[i];
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_miss <= '0;
    else
      r_miss <= bcd_add(r_miss, popcnt(w_miss_ev));
  end

  assign bus.total_miss = r_miss;
`else
  assign bus.total_miss = '0;
`endif

  for (genvar g = 0; g < N_MOLES; g++) begin : g_h
    assign bus.mheight[g*HW +: HW] = r_height[g];
  end

  assign bus.hiding      = r_hiding;
  assign bus.total_score = r_score;
  assign bus.total_rise  = r_rise;

endmodule
